// File: rtl/operand_frame_assembler.sv
// Collects a stream of DATA_W words into NUM_OPERANDS operands plus an opcode.
// A shadow set gathers the next frame while the previous one is still presented.
module operand_frame_assembler #(
    parameter int DATA_W        = 8,
    parameter int NUM_OPERANDS  = 2,
    parameter int OPERAND_WORDS = 2,
    parameter int TIMEOUT       = 16,
    localparam int FRAME_LEN    = NUM_OPERANDS * OPERAND_WORDS + 1,
    localparam int OPW          = OPERAND_WORDS * DATA_W,
    localparam int CNT_W        = $clog2(FRAME_LEN + 1)
) (
    input  logic                        i_clk,
    input  logic                        reset,
    input  logic                        i_ready,
    input  logic [DATA_W-1:0]           i_data,
    output logic                        o_in_ready,
    output logic                        o_done,
    input  logic                        i_ack,
    output logic [NUM_OPERANDS*OPW-1:0] o_operands,
    output logic [DATA_W-1:0]           o_opcode,
    output logic                        o_timeout,
    output logic [CNT_W-1:0]            o_word_cnt
);

    localparam int SHD_W  = NUM_OPERANDS * OPW;
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    generate
        if (NUM_OPERANDS < 1 || NUM_OPERANDS > 8 || OPERAND_WORDS < 1 ||
            OPERAND_WORDS > 4 || TIMEOUT < 0) begin : g_bad_params
            $error("operand_frame_assembler: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LAST, S_STALL} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic [SHD_W-1:0]    shadow;
    logic                accept, last_word, flush, done_nxt, tmo_nxt;

    // STALL means the opcode slot is next but the output frame is still unclaimed.
    assign o_in_ready = !(state == S_STALL && !i_ack);
    assign accept     = i_ready && o_in_ready;
    assign last_word  = accept && (cnt == LAST_CNT);
    assign flush      = (TIMEOUT > 0) && !accept && (cnt != '0) &&
                        (state != S_STALL) && (idle_cnt == IDLE_LIMIT);
    assign o_word_cnt = cnt;

    always_comb begin
        cnt_nxt   = cnt;
        idle_nxt  = idle_cnt;
        done_nxt  = o_done;
        tmo_nxt   = 1'b0;
        state_nxt = state;

        if (accept) begin
            cnt_nxt  = last_word ? '0 : cnt + 1'b1;
            idle_nxt = '0;
        end else if (flush) begin
            cnt_nxt  = '0;
            idle_nxt = '0;
            tmo_nxt  = 1'b1;
        end else if (cnt == '0) begin
            idle_nxt = '0;
        end else if (state != S_STALL && TIMEOUT > 0) begin
            idle_nxt = idle_cnt + 1'b1;
        end

        if (last_word)
            done_nxt = 1'b1;
        else if (i_ack && o_done)
            done_nxt = 1'b0;

        if (cnt_nxt == '0)
            state_nxt = S_IDLE;
        else if (cnt_nxt == LAST_CNT)
            state_nxt = done_nxt ? S_STALL : S_LAST;
        else
            state_nxt = S_COLLECT;
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idle_cnt   <= '0;
            shadow     <= '0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_operands <= '0;
            o_opcode   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idle_cnt  <= idle_nxt;
            o_done    <= done_nxt;
            o_timeout <= tmo_nxt;
            if (accept && !last_word)
                shadow[int'(cnt)*DATA_W +: DATA_W] <= i_data;
            else if (flush)
                shadow <= '0;
            // The opcode word goes straight to the output; operands come from the shadow set.
            if (last_word) begin
                o_operands <= shadow;
                o_opcode   <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_frame_assembler.sv
// Bench for operand_frame_assembler: directed scenarios plus randomized traffic
// checked against a queue-based frame model.
module tb_operand_frame_assembler;

    localparam int FL  = 5;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0, ack = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        in_rdy, done, tmo;
    logic [31:0] ops;
    logic [7:0]  opc;
    logic [2:0]  wcnt;

    logic        b_rdy = 1'b0, b_ack = 1'b0;
    logic [7:0]  b_din = 8'h00;
    logic        b_in_rdy, b_done, b_tmo;
    logic [23:0] b_ops;
    logic [7:0]  b_opc;
    logic [2:0]  b_wcnt;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0]  q[$];
    logic        m_done, m_tmo, m_in_rdy, act_in_rdy;
    logic [31:0] m_ops;
    logic [7:0]  m_opc;
    int          m_idle;

    operand_frame_assembler dut (
        .i_clk(clk), .reset(rst_n), .i_ready(rdy), .i_data(din), .o_in_ready(in_rdy),
        .o_done(done), .i_ack(ack), .o_operands(ops), .o_opcode(opc),
        .o_timeout(tmo), .o_word_cnt(wcnt)
    );

    operand_frame_assembler #(.DATA_W(8), .NUM_OPERANDS(3), .OPERAND_WORDS(1), .TIMEOUT(0)) dut_b (
        .i_clk(clk), .reset(rst_n), .i_ready(b_rdy), .i_data(b_din), .o_in_ready(b_in_rdy),
        .o_done(b_done), .i_ack(b_ack), .o_operands(b_ops), .o_opcode(b_opc),
        .o_timeout(b_tmo), .o_word_cnt(b_wcnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_done = 1'b0; m_tmo = 1'b0; m_ops = '0; m_opc = '0; m_idle = 0; m_in_rdy = 1'b1;
    endtask

    // Drives one cycle starting at a falling edge and advances the frame model.
    task automatic cycle(input logic r, input logic [7:0] d, input logic a);
        bit stall;
        rdy = r; din = d; ack = a;
        m_in_rdy = !(q.size() == FL - 1 && m_done && !a);
        stall = (q.size() == FL - 1) && m_done;
        #1 act_in_rdy = in_rdy;
        @(posedge clk);
        m_tmo = 1'b0;
        if (r && m_in_rdy) begin
            q.push_back(d);
            m_idle = 0;
            if (q.size() == FL) begin
                m_ops = '0;
                for (int i = 0; i < FL - 1; i++) m_ops[i*8 +: 8] = q[i];
                m_opc = d;
                m_done = 1'b1;
                q.delete();
            end else if (a && m_done) begin
                m_done = 1'b0;
            end
        end else begin
            if (a && m_done) m_done = 1'b0;
            if (q.size() == 0) m_idle = 0;
            else if (!stall) begin
                m_idle++;
                if (m_idle == TMO) begin
                    q.delete(); m_idle = 0; m_tmo = 1'b1;
                end
            end
        end
        @(negedge clk);
        rdy = 1'b0; ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done act=%0b exp=0", done); else n_pass++;
        n_checks++; if (wcnt !== 3'd0) $display("FAIL reset_wcnt act=%0d exp=0", wcnt); else n_pass++;
        n_checks++; if (ops !== 32'h0 || opc !== 8'h0) $display("FAIL reset_regs act=%h/%h exp=0/0", ops, opc); else n_pass++;
        n_checks++; if (tmo !== 1'b0) $display("FAIL reset_tmo act=%0b exp=0", tmo); else n_pass++;
        n_checks++; if (in_rdy !== 1'b1) $display("FAIL reset_in_ready act=%0b exp=1", in_rdy); else n_pass++;
        #2 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] w[5] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hA5};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, w[i], 1'b0);
            if (i < 4) begin
                n_checks++; if (wcnt !== 3'(i + 1)) $display("FAIL basic_wcnt act=%0d exp=%0d", wcnt, i + 1); else n_pass++;
            end
        end
        n_checks++; if (done !== 1'b1) $display("FAIL basic_done act=%0b exp=1", done); else n_pass++;
        n_checks++; if (ops !== 32'h56781234) $display("FAIL basic_ops act=%h exp=56781234", ops); else n_pass++;
        n_checks++; if (opc !== 8'hA5) $display("FAIL basic_opc act=%h exp=a5", opc); else n_pass++;
        n_checks++; if (wcnt !== 3'd0) $display("FAIL basic_wcnt_end act=%0d exp=0", wcnt); else n_pass++;
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (done !== 1'b1 || ops !== 32'h56781234) $display("FAIL basic_hold act=%0b/%h exp=1/56781234", done, ops); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_ack act=%0b exp=0", done); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++; if (done !== 1'b0 || ops !== 32'h56781234) $display("FAIL basic_idle_ack act=%0b/%h exp=0/56781234", done, ops); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] f1[5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3C};
        logic [7:0] f2[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        for (int i = 0; i < 5; i++) cycle(1'b1, f1[i], 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, f2[i], 1'b0);
        n_checks++; if (wcnt !== 3'd4) $display("FAIL b2b_wcnt act=%0d exp=4", wcnt); else n_pass++;
        n_checks++; if (done !== 1'b1 || ops !== 32'hDEADBEEF || opc !== 8'h3C) $display("FAIL b2b_old_frame act=%0b/%h/%h exp=1/deadbeef/3c", done, ops, opc); else n_pass++;
        cycle(1'b1, f2[4], 1'b0);
        n_checks++; if (act_in_rdy !== 1'b0) $display("FAIL b2b_stall_ready act=%0b exp=0", act_in_rdy); else n_pass++;
        n_checks++; if (wcnt !== 3'd4 || ops !== 32'hDEADBEEF || done !== 1'b1) $display("FAIL b2b_stall_hold act=%0d/%h/%0b exp=4/deadbeef/1", wcnt, ops, done); else n_pass++;
        cycle(1'b1, f2[4], 1'b1);
        n_checks++; if (act_in_rdy !== 1'b1) $display("FAIL b2b_ack_ready act=%0b exp=1", act_in_rdy); else n_pass++;
        n_checks++; if (done !== 1'b1 || ops !== 32'h44332211 || opc !== 8'h5A || wcnt !== 3'd0) $display("FAIL b2b_new_frame act=%0b/%h/%h/%0d exp=1/44332211/5a/0", done, ops, opc, wcnt); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++; if (done !== 1'b0) $display("FAIL b2b_release act=%0b exp=0", done); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [7:0] f[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0F};
        for (int i = 0; i < 5; i++) cycle(1'b1, f[i] ^ 8'h80, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (k < 16) begin
                n_checks++; if (tmo !== 1'b0) $display("FAIL tmo_early idle=%0d act=%0b exp=0", k, tmo); else n_pass++;
            end
        end
        n_checks++; if (tmo !== 1'b1) $display("FAIL tmo_pulse act=%0b exp=1", tmo); else n_pass++;
        n_checks++; if (wcnt !== 3'd0) $display("FAIL tmo_wcnt act=%0d exp=0", wcnt); else n_pass++;
        n_checks++; if (done !== 1'b1 || ops !== 32'h84838281) $display("FAIL tmo_outputs act=%0b/%h exp=1/84838281", done, ops); else n_pass++;
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (tmo !== 1'b0) $display("FAIL tmo_one_cycle act=%0b exp=0", tmo); else n_pass++;
        for (int i = 0; i < 5; i++) cycle(1'b1, f[i], i == 4);
        n_checks++; if (done !== 1'b1 || ops !== 32'h04030201 || opc !== 8'h0F) $display("FAIL tmo_next_frame act=%0b/%h/%h exp=1/04030201/0f", done, ops, opc); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_timeout_race();
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        for (int k = 1; k <= 15; k++) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        n_checks++; if (tmo !== 1'b0) $display("FAIL race_tmo act=%0b exp=0", tmo); else n_pass++;
        n_checks++; if (wcnt !== 3'd3) $display("FAIL race_wcnt act=%0d exp=3", wcnt); else n_pass++;
        cycle(1'b1, 8'hC4, 1'b0);
        cycle(1'b1, 8'hC5, 1'b0);
        n_checks++; if (done !== 1'b1 || ops !== 32'hC4C3C2C1 || opc !== 8'hC5) $display("FAIL race_frame act=%0b/%h/%h exp=1/c4c3c2c1/c5", done, ops, opc); else n_pass++;
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (done !== 1'b0 || wcnt !== 3'd0 || tmo !== 1'b0) $display("FAIL areset_ctrl act=%0b/%0d/%0b exp=0/0/0", done, wcnt, tmo); else n_pass++;
        n_checks++; if (ops !== 32'h0 || opc !== 8'h0) $display("FAIL areset_regs act=%h/%h exp=0/0", ops, opc); else n_pass++;
        n_checks++; if (in_rdy !== 1'b1) $display("FAIL areset_ready act=%0b exp=1", in_rdy); else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0);
        n_checks++; if (done !== 1'b1 || ops !== 32'h93929190 || opc !== 8'h94) $display("FAIL areset_frame act=%0b/%h/%h exp=1/93929190/94", done, ops, opc); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r, a;
            r = ((i / 50) % 3 == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
            a = ($urandom_range(0, 2) == 0);
            cycle(r, 8'($urandom), a);
            n_checks++; if (act_in_rdy !== m_in_rdy) $display("FAIL rnd_in_ready cyc=%0d act=%0b exp=%0b", i, act_in_rdy, m_in_rdy); else n_pass++;
            n_checks++; if (done !== m_done) $display("FAIL rnd_done cyc=%0d act=%0b exp=%0b", i, done, m_done); else n_pass++;
            n_checks++; if (wcnt !== 3'(q.size())) $display("FAIL rnd_wcnt cyc=%0d act=%0d exp=%0d", i, wcnt, q.size()); else n_pass++;
            n_checks++; if (tmo !== m_tmo) $display("FAIL rnd_tmo cyc=%0d act=%0b exp=%0b", i, tmo, m_tmo); else n_pass++;
            n_checks++; if (ops !== m_ops || opc !== m_opc) $display("FAIL rnd_frame cyc=%0d act=%h/%h exp=%h/%h", i, ops, opc, m_ops, m_opc); else n_pass++;
        end
    endtask

    task automatic test_no_timeout();
        logic [7:0] w[4] = '{8'h01, 8'h02, 8'h03, 8'h09};
        bit seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_rdy = 1'b1; b_din = w[i];
            @(posedge clk); @(negedge clk);
        end
        b_rdy = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b_tmo) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL nt_tmo act=%0b exp=0", seen); else n_pass++;
        n_checks++; if (b_ops !== 24'h030201 || b_opc !== 8'h09) $display("FAIL nt_frame act=%h/%h exp=030201/09", b_ops, b_opc); else n_pass++;
        n_checks++; if (b_done !== 1'b1 || b_wcnt !== 3'd0) $display("FAIL nt_done act=%0b/%0d exp=1/0", b_done, b_wcnt); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_async_reset();
        test_random();
        test_no_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
